// File: rtl/rf_pkg.sv
// Shared sizing and types for the CPU register file and its read ports.
// Register 0 is architectural zero and has no storage behind it.
package rf_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational, zero-masked read port over the register storage.
// Address 0 selects no entry, so the AND-OR mux naturally yields zero.
module regfile_read_port
    import rf_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  reg_data_t             regs [1:NUM_REGS-1],
    output logic [DATA_WIDTH-1:0] read_result
);

    logic [NUM_REGS-1:1] hit;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_hit
            assign hit[gi] = (read_addr == ADDR_WIDTH'(gi));
        end
    endgenerate

    // One-hot select, so OR-ing the masked entries is an exact mux.
    always_comb begin
        read_result = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            read_result = read_result | (regs[i] & {DATA_WIDTH{hit[i]}});
        end
    end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write port,
// register 0 hard-wired to zero, asynchronous active-low clear.
module regfile
    import rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] read_result1,
    output logic [DATA_WIDTH-1:0] read_result2
);

    reg_data_t           regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] wr_sel;

    // Write decode; there is no select for REG_ZERO, so writes to it vanish.
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_wr_sel
            assign wr_sel[gi] = write_enable && (write_addr == ADDR_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= write_data;
                end
            end
        end
    end

    // No write-to-read bypass: forwarding is handled in the pipeline.
    regfile_read_port u_read_port1 (
        .read_addr   (read_addr1),
        .regs        (regs),
        .read_result (read_result1)
    );

    regfile_read_port u_read_port2 (
        .read_addr   (read_addr2),
        .regs        (regs),
        .read_result (read_result2)
    );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus pushes expected read values from an
// array model; a monitor pops and compares at negedge or on demand.
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_result1;
    logic [31:0] read_result2;

    regfile dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_addr1   (read_addr1),
        .read_addr2   (read_addr2),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_result1 (read_result1),
        .read_result2 (read_result2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    event        chk_ev;
    int          checks;
    int          failures;

    // Reference model: plain array of architectural register values.
    logic [31:0] model [32];
    logic        pend_we;
    logic [4:0]  pend_wa;
    logic [31:0] pend_wd;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: consumes every queued expectation when the DUT is sampled.
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                compare({e.name, "_p1"}, read_result1, e.exp1);
                compare({e.name, "_p2"}, read_result2, e.exp2);
                $display("txn %-10s r1=%08h r2=%08h exp1=%08h exp2=%08h",
                         e.name, read_result1, read_result2, e.exp1, e.exp2);
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        pend_we = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[a];
    endfunction

    // One cycle: the previously driven write commits at this edge, then the
    // new inputs are driven and the pre-edge read values are expected.
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra1, input logic [4:0] ra2, input string name);
        sb_entry_t e;
        @(posedge clk);
        if (rst_n && pend_we && wa !== 5'bx && pend_wa != 5'd0) model[pend_wa] = pend_wd;
        #1;
        write_enable = we;
        write_addr   = wa;
        write_data   = wd;
        read_addr1   = ra1;
        read_addr2   = ra2;
        pend_we = we;
        pend_wa = wa;
        pend_wd = wd;
        e.name = name;
        e.exp1 = model_read(ra1);
        e.exp2 = model_read(ra2);
        sb_q.push_back(e);
    endtask

    initial begin
        sb_entry_t e;
        int        wait_cycles;
        checks   = 0;
        failures = 0;
        rst_n        = 1'b0;
        write_enable = 1'b0;
        write_addr   = 5'd0;
        write_data   = 32'h0;
        read_addr1   = 5'd0;
        read_addr2   = 5'd0;
        model_clear();

        step(1'b1, 5'd3, 32'h11111111, 5'd3, 5'd3, "in_reset");
        pend_we = 1'b0;      // reset held across the edge, write must be lost
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        rst_n = 1'b1;

        step(1'b0, 5'd0, 32'h0,         5'd1, 5'd2, "rst_state");
        step(1'b1, 5'd0, 32'hdeedbeef,  5'd0, 5'd0, "w0_pre");
        step(1'b0, 5'd0, 32'hdeedbeef,  5'd0, 5'd0, "w0_post");
        step(1'b1, 5'd2, 32'h42424242,  5'd1, 5'd2, "w2_pre");
        step(1'b0, 5'd2, 32'hdeedbeef,  5'd1, 5'd2, "w2_post");
        for (int i = 0; i < 3; i++)
            step(1'b0, 5'd2, 32'hdeedbeef, 5'd2, 5'd2, "w_dis");
        step(1'b1, 5'd5, 32'h42424242,  5'd2, 5'd5, "w5");
        step(1'b1, 5'd7, 32'h12345678,  5'd5, 5'd2, "pre_rst");

        // Mid-cycle asynchronous reset while a write to reg 7 is pending.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        write_enable = 1'b0;
        model_clear();
        #1;
        e.name = "rst_async";
        e.exp1 = 32'h0;
        e.exp2 = 32'h0;
        sb_q.push_back(e);
        -> chk_ev;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd2, "post_rst");
        step(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "post_rst7");

        step(1'b1, 5'd31, 32'h00000031, 5'd31, 5'd31, "r31_w1");
        step(1'b1, 5'd31, 32'hffffffff, 5'd31, 5'd31, "r31_old");
        step(1'b0, 5'd0,  32'h0,        5'd31, 5'd31, "r31_new");

        for (int i = 0; i < 32; i++)
            step(1'b1, 5'(i), 32'h10000000 | i, 5'(i), 5'(31 - i), "sweep_w");
        for (int i = 0; i < 32; i++)
            step(1'b0, 5'(i), 32'hcafef00d, 5'(i), 5'(i), "sweep_r");

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "drain");

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
